// File: rtl/stack_pkg.sv
// Shared constants for the stack command front-end: opcodes, response codes,
// sequencer state encoding and the depth of the downstream stack.
package stack_pkg;

  localparam int DEPTH = 16;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_OVF = 2'b01;
  localparam logic [1:0] RSP_UNF = 2'b10;
  localparam logic [1:0] RSP_ILL = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PUSH   = 4'd1,
    ST_POP_A  = 4'd2,
    ST_WAIT_A = 4'd3,
    ST_POP_B  = 4'd4,
    ST_WAIT_B = 4'd5,
    ST_EXEC   = 4'd6,
    ST_PUSH_R = 4'd7,
    ST_WAIT_P = 4'd8,
    ST_RESP   = 4'd9
  } state_t;

  function automatic logic is_binary_op(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the RPN sequencer: r = b op a, where a was the top of
// stack and b the word beneath it. Non-ALU opcodes yield zero.
module stack_alu
  import stack_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = b + a;
      OP_SUB:  r = b - a;
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
      OP_XOR:  r = b ^ a;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Command front-end for a 16-entry stack: turns PUSH/POP/ALU commands into
// stack pulses, waits the stack's fixed latency, and returns one response per command.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int STK_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_error,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_code
);

  localparam int CW = (STK_LAT > 1) ? $clog2(STK_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STK_LAT - 1);

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_r;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and responses are single-cycle pulses with
  // no backpressure, always issued before the next command can be accepted.
  assign cmd_ready = (state == ST_IDLE);

  stack_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (alu_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      op_q        <= OP_PUSH;
      a_q         <= '0;
      b_q         <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_code    <= RSP_OK;
    end else begin
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            if (cmd_op == OP_PUSH) begin
              stk_data_in <= cmd_data;
              stk_push    <= 1'b1;
              state       <= ST_PUSH;
            end else if (cmd_op == OP_POP || is_binary_op(cmd_op)) begin
              stk_pop <= 1'b1;
              state   <= ST_POP_A;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_code  <= RSP_ILL;
              state     <= ST_RESP;
            end
          end
        end

        // Pulse states: the pulse register is already high; arm the latency counter.
        ST_PUSH, ST_PUSH_R: begin
          wait_cnt <= CNT_INIT;
          state    <= ST_WAIT_P;
        end

        ST_POP_A: begin
          wait_cnt <= CNT_INIT;
          state    <= ST_WAIT_A;
        end

        ST_WAIT_A: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else if (stk_error) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_code  <= RSP_UNF;
            state     <= ST_RESP;
          end else if (op_q == OP_POP) begin
            rsp_valid <= 1'b1;
            rsp_data  <= stk_data_out;
            rsp_code  <= RSP_OK;
            state     <= ST_RESP;
          end else begin
            a_q     <= stk_data_out;
            stk_pop <= 1'b1;
            state   <= ST_POP_B;
          end
        end

        ST_POP_B: begin
          wait_cnt <= CNT_INIT;
          state    <= ST_WAIT_B;
        end

        // An underflow here leaves A consumed; it is deliberately not restored.
        ST_WAIT_B: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else if (stk_error) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_code  <= RSP_UNF;
            state     <= ST_RESP;
          end else begin
            b_q   <= stk_data_out;
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          stk_data_in <= alu_r;
          stk_push    <= 1'b1;
          state       <= ST_PUSH_R;
        end

        // stk_data_in still holds the pushed word, which is also the response data.
        ST_WAIT_P: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= stk_data_in;
            rsp_code  <= stk_error ? RSP_OVF : RSP_OK;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a behavioural 16-entry stack with fixed latency,
// a queue-based reference calculator, and a monitor that checks every response.
module tb_stack_sequencer;
  import stack_pkg::*;

  localparam int DATA_W  = 8;
  localparam int STK_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_data_out;
  logic              stk_error;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_code;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stack_sequencer #(.DATA_W(DATA_W), .STK_LAT(STK_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_error    (stk_error),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_code     (rsp_code)
  );

  // ---------------- behavioural stack ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  int                sp;
  logic [DATA_W-1:0] d_pipe [STK_LAT];
  logic              e_pipe [STK_LAT];

  assign stk_data_out = d_pipe[STK_LAT-1];
  assign stk_error    = e_pipe[STK_LAT-1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
      for (int i = 0; i < STK_LAT; i++) begin
        d_pipe[i] <= '0;
        e_pipe[i] <= 1'b0;
      end
    end else begin
      for (int i = STK_LAT - 1; i >= 1; i--) begin
        d_pipe[i] <= d_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
      if (stk_push) begin
        d_pipe[0] <= stk_data_in;
        if (sp == DEPTH) begin
          e_pipe[0] <= 1'b1;
        end else begin
          mem[sp]   <= stk_data_in;
          sp        <= sp + 1;
          e_pipe[0] <= 1'b0;
        end
      end else if (stk_pop) begin
        if (sp == 0) begin
          d_pipe[0] <= DATA_W'($urandom);
          e_pipe[0] <= 1'b1;
        end else begin
          d_pipe[0] <= mem[sp-1];
          sp        <= sp - 1;
          e_pipe[0] <= 1'b0;
        end
      end else begin
        // Garbage outside valid windows exposes sampling at the wrong cycle.
        d_pipe[0] <= DATA_W'($urandom);
        e_pipe[0] <= 1'($urandom);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0]        exp_q [$];
  int                lat_q [$];
  int                acc_q [$];
  bit                ill_q [$];
  logic [DATA_W-1:0] mdl [$];
  int                vectors = 0;
  int                miscompares = 0;
  int                last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return b + a;
      OP_SUB:  return b - a;
      OP_AND:  return b & a;
      OP_OR:   return b | a;
      default: return b ^ a;
    endcase
  endfunction

  task automatic expect_rsp(input logic [1:0] code, input logic [DATA_W-1:0] d,
                            input int lat, input bit ill, input int acc);
    exp_q.push_back({code, d});
    lat_q.push_back(lat);
    acc_q.push_back(acc);
    ill_q.push_back(ill);
  endtask

  // Reference calculator: stack as a queue, latency from the command class.
  task automatic model_cmd(input logic [2:0] op, input logic [DATA_W-1:0] d, input int acc);
    logic [DATA_W-1:0] a, b;
    if (op == OP_PUSH) begin
      if (mdl.size() == DEPTH) expect_rsp(RSP_OVF, d, STK_LAT + 2, 1'b0, acc);
      else begin
        mdl.push_back(d);
        expect_rsp(RSP_OK, d, STK_LAT + 2, 1'b0, acc);
      end
    end else if (op == OP_POP) begin
      if (mdl.size() == 0) expect_rsp(RSP_UNF, '0, STK_LAT + 2, 1'b0, acc);
      else expect_rsp(RSP_OK, mdl.pop_back(), STK_LAT + 2, 1'b0, acc);
    end else if (op == OP_ILL) begin
      expect_rsp(RSP_ILL, '0, 1, 1'b1, acc);
    end else if (mdl.size() == 0) begin
      expect_rsp(RSP_UNF, '0, -1, 1'b0, acc);
    end else if (mdl.size() == 1) begin
      void'(mdl.pop_back());
      expect_rsp(RSP_UNF, '0, -1, 1'b0, acc);
    end else begin
      a = mdl.pop_back();
      b = mdl.pop_back();
      mdl.push_back(ref_alu(op, a, b));
      expect_rsp(RSP_OK, ref_alu(op, a, b), 3 * STK_LAT + 5, 1'b0, acc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [9:0] m_exp;
  int         m_lat;
  int         m_acc;

  always @(negedge clk) begin
    chk("push_pop_excl", {31'd0, stk_push & stk_pop}, 32'd0);
    if (ill_q.size() > 0 && ill_q[0]) chk("ill_no_pulse", {30'd0, stk_push, stk_pop}, 32'd0);
    if (exp_q.size() > 0) chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got code %0h data %0h expected none (cycle %0d)",
                 rsp_code, rsp_data, cyc);
      end else begin
        m_exp = exp_q.pop_front();
        m_lat = lat_q.pop_front();
        m_acc = acc_q.pop_front();
        void'(ill_q.pop_front());
        chk("rsp_code", {30'd0, rsp_code}, {30'd0, m_exp[9:8]});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, m_exp[7:0]});
        if (m_lat >= 0) chk("rsp_latency", cyc - m_acc, m_lat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] d);
    int budget;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    budget    = 0;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      last_acc = cyc;
      @(posedge clk);
      model_cmd(op, d, last_acc);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_stk_push", {31'd0, stk_push}, 32'd0);
    chk("rst_stk_pop", {31'd0, stk_pop}, 32'd0);
    chk("rst_stk_data_in", {24'd0, stk_data_in}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_rsp_code", {30'd0, rsp_code}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op;
    int         sel;
    int         budget;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_PUSH;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // basic RPN subtract, then read back
    issue(OP_PUSH, 8'h05);
    issue(OP_PUSH, 8'h03);
    issue(OP_SUB, 8'h00);
    issue(OP_POP, 8'h00);
    // wrap-around arithmetic
    issue(OP_PUSH, 8'h01);
    issue(OP_PUSH, 8'h03);
    issue(OP_SUB, 8'h00);
    issue(OP_PUSH, 8'hFF);
    issue(OP_PUSH, 8'h02);
    issue(OP_ADD, 8'h00);
    issue(OP_POP, 8'h00);
    issue(OP_POP, 8'h00);
    drain();

    // fill to capacity, overflow, empty back out
    for (int i = 0; i < DEPTH; i++) issue(OP_PUSH, DATA_W'(i));
    issue(OP_PUSH, 8'hAA);
    for (int i = 0; i < DEPTH; i++) issue(OP_POP, 8'h00);
    drain();

    // underflow paths, illegal op
    issue(OP_POP, 8'h00);
    issue(OP_PUSH, 8'h07);
    issue(OP_XOR, 8'h00);
    issue(OP_POP, 8'h00);
    issue(OP_ILL, 8'h5C);
    issue(OP_PUSH, 8'hC3);
    issue(OP_PUSH, 8'h3C);
    issue(OP_OR, 8'h00);
    drain();

    // reset during WAIT_B of an ADD
    issue(OP_PUSH, 8'h10);
    issue(OP_PUSH, 8'h20);
    issue(OP_ADD, 8'h00);
    budget = 0;
    while (cyc != last_acc + 3 + STK_LAT && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("reach_wait_b", cyc - last_acc, 3 + STK_LAT);
    #1;
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    ill_q.delete();
    mdl.delete();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midop_reset", {31'd0, cmd_ready}, 32'd1);
    check_reset_outputs();

    // randomized command mix
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      op = OP_PUSH;
      else if (sel <= 5) op = OP_POP;
      else if (sel <= 8) op = 3'($urandom_range(2, 6));
      else               op = OP_ILL;
      issue(op, DATA_W'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
